// File: rtl/tv80_pkg.sv
// Shared TV80 constants: flag bit positions, 16-bit op encodings and the
// 8-bit ALU op codes used when sequencing 16-bit arithmetic.
`timescale 1ns/1ps
package tv80_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_P = 2;
    localparam int FLAG_X = 3;
    localparam int FLAG_H = 4;
    localparam int FLAG_Y = 5;
    localparam int FLAG_Z = 6;
    localparam int FLAG_S = 7;

    typedef enum logic [1:0] {
        OP_ADD16 = 2'b00,
        OP_ADC16 = 2'b01,
        OP_SBC16 = 2'b10,
        OP_RSVD  = 2'b11
    } alu16_op_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_ADC = 4'b0001;
    localparam logic [3:0] ALU_SBC = 4'b0011;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    function automatic logic [7:0] flag_bit(input int idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/tv80_alu16_seq.sv
// 16-bit ADD/ADC/SBC sequencer: runs one 16-bit op as two passes through the
// external 8-bit ALU, low byte first, high byte with the chained flags.
//
// state | meaning
// IDLE  | waiting for start, ALU bus parked
// LO    | low bytes on the ALU, flags captured into f_lo_q
// HI    | high bytes on the ALU, final flags captured into f_out
// DONE  | result strobe; a start here begins the next op immediately
`timescale 1ns/1ps
module tv80_alu16_seq
    import tv80_pkg::*;
#(
    parameter int Flag_C = FLAG_C,
    parameter int Flag_N = FLAG_N,
    parameter int Flag_P = FLAG_P,
    parameter int Flag_X = FLAG_X,
    parameter int Flag_H = FLAG_H,
    parameter int Flag_Y = FLAG_Y,
    parameter int Flag_Z = FLAG_Z,
    parameter int Flag_S = FLAG_S
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  logic [7:0]  f_in,
    output logic        ready,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  f_out,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_busa,
    output logic [7:0]  alu_busb,
    output logic [7:0]  alu_f_in,
    output logic        alu_arith16,
    output logic        alu_z16,
    input  logic [7:0]  alu_q,
    input  logic [7:0]  alu_f_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // S/Z/P may be inherited from f_in; everything else is owned by the high byte.
    localparam logic [7:0] SZP_MASK = flag_bit(Flag_S) | flag_bit(Flag_Z) | flag_bit(Flag_P);
    localparam logic [7:0] HI_MASK  = flag_bit(Flag_C) | flag_bit(Flag_N) | flag_bit(Flag_X)
                                    | flag_bit(Flag_H) | flag_bit(Flag_Y);

    logic [1:0]  state_q, state_d;
    alu16_op_e   op_q, op_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [7:0]  f_in_q, f_in_d;
    logic [7:0]  f_lo_q, f_lo_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  f_out_q, f_out_d;

    logic        add_mode;
    logic [7:0]  szp_src;

    assign ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign f_out    = f_out_q;
    assign add_mode = (op_q == OP_ADD16) || (op_q == OP_RSVD);
    assign szp_src  = add_mode ? f_in_q : alu_f_out;

    always_comb begin
        alu_op      = ALU_NOP;
        alu_busa    = 8'h00;
        alu_busb    = 8'h00;
        alu_f_in    = 8'h00;
        alu_arith16 = 1'b0;
        alu_z16     = 1'b0;
        case (state_q)
            ST_LO: begin
                alu_busa = opa_q[7:0];
                alu_busb = opb_q[7:0];
                alu_f_in = f_in_q;
                case (op_q)
                    OP_ADC16: alu_op = ALU_ADC;
                    OP_SBC16: alu_op = ALU_SBC;
                    default: begin
                        alu_op      = ALU_ADD;
                        alu_arith16 = 1'b1;
                    end
                endcase
            end
            ST_HI: begin
                alu_busa = opa_q[15:8];
                alu_busb = opb_q[15:8];
                alu_f_in = f_lo_q;
                case (op_q)
                    OP_ADC16: begin
                        alu_op  = ALU_ADC;
                        alu_z16 = 1'b1;
                    end
                    OP_SBC16: begin
                        alu_op  = ALU_SBC;
                        alu_z16 = 1'b1;
                    end
                    default: begin
                        alu_op      = ALU_ADC;
                        alu_arith16 = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        f_in_d   = f_in_q;
        f_lo_d   = f_lo_q;
        result_d = result_q;
        f_out_d  = f_out_q;
        case (state_q)
            ST_LO: begin
                state_d       = ST_HI;
                result_d[7:0] = alu_q;
                f_lo_d        = alu_f_out;
            end
            ST_HI: begin
                state_d        = ST_DONE;
                result_d[15:8] = alu_q;
                f_out_d        = (alu_f_out & HI_MASK) | (szp_src & SZP_MASK);
            end
            default: begin
                if (start) begin
                    state_d = ST_LO;
                    op_d    = alu16_op_e'(op);
                    opa_d   = opa;
                    opb_d   = opb;
                    f_in_d  = f_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD16;
            opa_q    <= 16'h0000;
            opb_q    <= 16'h0000;
            f_in_q   <= 8'h00;
            f_lo_q   <= 8'h00;
            result_q <= 16'h0000;
            f_out_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            f_in_q   <= f_in_d;
            f_lo_q   <= f_lo_d;
            result_q <= result_d;
            f_out_q  <= f_out_d;
        end
    end

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// Bench for tv80_alu16_seq: behavioural 8-bit ALU on the alu_* bus, a 16-bit
// arithmetic reference model, and a queue-based scoreboard checked by a monitor.
`timescale 1ns/1ps
module tb_tv80_alu16_seq;
    import tv80_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] opa = 16'h0000;
    logic [15:0] opb = 16'h0000;
    logic [7:0]  f_in = 8'h00;
    logic        ready, done;
    logic [15:0] result;
    logic [7:0]  f_out;
    logic [3:0]  alu_op;
    logic [7:0]  alu_busa, alu_busb, alu_f_in;
    logic        alu_arith16, alu_z16;
    logic [7:0]  alu_q, alu_f_out;

    typedef struct {
        logic [15:0] r;
        logic [7:0]  f;
        int          t;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          last_issue = -100;
    logic [15:0] last_res = 16'h0000;
    logic [7:0]  last_f = 8'h00;

    always #5 clk = ~clk;

    tv80_alu16_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
        .f_in(f_in), .ready(ready), .done(done), .result(result), .f_out(f_out),
        .alu_op(alu_op), .alu_busa(alu_busa), .alu_busb(alu_busb), .alu_f_in(alu_f_in),
        .alu_arith16(alu_arith16), .alu_z16(alu_z16), .alu_q(alu_q), .alu_f_out(alu_f_out)
    );

    // 8-bit ALU add/sub group: op[1] subtract, op[0] use carry.
    function automatic logic [15:0] alu8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] fi, input logic ar16, input logic z16);
        logic [8:0] s;
        logic [4:0] h;
        int         sr;
        logic [7:0] q, fo;
        logic       cin;
        q  = 8'h00;
        fo = fi;
        if (o[3:2] == 2'b00) begin
            cin = o[0] & fi[FLAG_C];
            if (o[1]) begin
                s  = {1'b0, a} - {1'b0, b} - {8'b0, cin};
                h  = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, cin};
                sr = int'($signed(a)) - int'($signed(b)) - int'(cin);
            end else begin
                s  = {1'b0, a} + {1'b0, b} + {8'b0, cin};
                h  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
                sr = int'($signed(a)) + int'($signed(b)) + int'(cin);
            end
            q         = s[7:0];
            fo[FLAG_C] = s[8];
            fo[FLAG_H] = h[4];
            fo[FLAG_N] = o[1];
            fo[FLAG_P] = (sr > 127) || (sr < -128);
            fo[FLAG_X] = q[3];
            fo[FLAG_Y] = q[5];
            fo[FLAG_S] = q[7];
            fo[FLAG_Z] = (q == 8'h00) ? (z16 ? fi[FLAG_Z] : 1'b1) : 1'b0;
            if (ar16) begin
                fo[FLAG_S] = fi[FLAG_S];
                fo[FLAG_Z] = fi[FLAG_Z];
                fo[FLAG_P] = fi[FLAG_P];
            end
        end
        return {q, fo};
    endfunction

    // 16-bit reference: whole-word arithmetic, no byte split.
    function automatic logic [23:0] ref16(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                          input logic [7:0] fi);
        logic [16:0] s;
        logic [12:0] h;
        int          sr;
        logic [7:0]  fo;
        logic        c, is_add;
        is_add = (o == 2'b00) || (o == 2'b11);
        c  = is_add ? 1'b0 : fi[FLAG_C];
        fo = 8'h00;
        if (o == 2'b10) begin
            s  = {1'b0, a} - {1'b0, b} - {16'b0, c};
            h  = {1'b0, a[11:0]} - {1'b0, b[11:0]} - {12'b0, c};
            sr = int'($signed(a)) - int'($signed(b)) - int'(c);
            fo[FLAG_N] = 1'b1;
        end else begin
            s  = {1'b0, a} + {1'b0, b} + {16'b0, c};
            h  = {1'b0, a[11:0]} + {1'b0, b[11:0]} + {12'b0, c};
            sr = int'($signed(a)) + int'($signed(b)) + int'(c);
        end
        fo[FLAG_C] = s[16];
        fo[FLAG_H] = h[12];
        fo[FLAG_X] = s[11];
        fo[FLAG_Y] = s[13];
        if (is_add) begin
            fo[FLAG_S] = fi[FLAG_S];
            fo[FLAG_Z] = fi[FLAG_Z];
            fo[FLAG_P] = fi[FLAG_P];
        end else begin
            fo[FLAG_S] = s[15];
            fo[FLAG_Z] = (s[15:0] == 16'h0000);
            fo[FLAG_P] = (sr > 32767) || (sr < -32768);
        end
        return {s[15:0], fo};
    endfunction

    always_comb begin
        {alu_q, alu_f_out} = alu8(alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: samples 1ns after each rising edge.
    always @(posedge clk) begin
        logic exp_busy, exp_done;
        exp_t e;
        cyc++;
        #1;
        if (reset) begin
            sb.delete();
            last_issue = -100;
            last_res   = 16'h0000;
            last_f     = 8'h00;
            chk("rst_ready", 32'(ready), 32'd1);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_result", 32'(result), 32'h0);
            chk("rst_f_out", 32'(f_out), 32'h0);
        end else begin
            exp_busy = (cyc > last_issue) && (cyc <= last_issue + 2);
            exp_done = (sb.size() > 0) && (cyc - sb[0].t == 3);
            chk("ready", 32'(ready), 32'(!exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            if (!exp_busy)
                chk("alu_park", 32'({alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16}),
                    32'({4'hF, 26'b0}));
            if (exp_done) begin
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.r));
                chk("f_out", 32'(f_out), 32'(e.f));
                last_res = e.r;
                last_f   = e.f;
            end else if (!exp_busy) begin
                chk("hold", 32'({result, f_out}), 32'({last_res, last_f}));
            end
        end
    end

    task automatic scramble();
        op   = 2'($urandom_range(0, 3));
        opa  = 16'($urandom);
        opb  = 16'($urandom);
        f_in = 8'($urandom);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(negedge clk);
            scramble();
        end
    endtask

    // Called at a negedge where the DUT is ready; returns at the DONE negedge.
    task automatic issue_exp(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                             input logic [7:0] f, input logic [15:0] er, input logic [7:0] ef,
                             input bit poke);
        exp_t e;
        start = 1'b1;
        op = o; opa = a; opb = b; f_in = f;
        e.r = er; e.f = ef; e.t = cyc;
        sb.push_back(e);
        last_issue = cyc;
        repeat (2) begin
            @(negedge clk);
            start = poke;
            scramble();
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] f, input bit poke);
        logic [23:0] rf;
        rf = ref16(o, a, b, f);
        issue_exp(o, a, b, f, rf[23:8], rf[7:0], poke);
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(2);

        issue_exp(2'b00, 16'h0FFF, 16'h0001, 8'h00, 16'h1000, 8'h10, 1'b0);
        issue_exp(2'b01, 16'hFFFF, 16'h0000, 8'h01, 16'h0000, 8'h51, 1'b1);
        issue_exp(2'b10, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 8'h3E, 1'b1);
        issue_exp(2'b10, 16'h0100, 16'h0100, 8'h00, 16'h0000, 8'h42, 1'b0);
        issue_exp(2'b01, 16'h0100, 16'h0000, 8'h00, 16'h0100, 8'h00, 1'b0);
        issue(2'b11, 16'h1234, 16'h0F0F, 8'hC4, 1'b1);
        idle(2);

        // abort in HI
        start = 1'b1; op = 2'b01; opa = 16'hABCD; opb = 16'h1111; f_in = 8'h01;
        last_issue = cyc;
        @(negedge clk); start = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        idle(4);

        issue(2'b10, 16'h5555, 16'h1234, 8'h01, 1'b0);
        idle(1);
        // abort in LO
        start = 1'b1; op = 2'b00; opa = 16'h7777; opb = 16'h8888; f_in = 8'hFF;
        last_issue = cyc;
        @(negedge clk); start = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        idle(4);

        // reset and start together: reset wins
        start = 1'b1; reset = 1'b1; op = 2'b01; opa = 16'h4321; opb = 16'h1234; f_in = 8'h00;
        @(negedge clk); start = 1'b0; reset = 1'b0;
        idle(5);

        for (int i = 0; i < 200; i++) begin
            issue(2'($urandom_range(0, 3)), pick16(), pick16(), 8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0)
                idle($urandom_range(1, 3));
        end
        idle(6);
        chk("drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
